// File: rtl/pll_lock_ctrl.sv
// PLL lock sequencer: timed PLL reset, debounced lock detect, retry on timeout, fault latch.
// Optional loss-of-lock statistics counter built when PLL_LOCK_CTRL_STAT_EN is defined.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_FILT      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_fault,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             fault,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [2:0]       state
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned FLT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    FILTER    = 3'd3,
    READY     = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t           st;
  state_t           nxt_c;
  state_t           tmo_dst_c;
  logic             sync1;
  logic             locked_s;
  logic [RST_W-1:0] rst_cnt;
  logic [FLT_W-1:0] filt_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry;
  logic             rst_done_c;
  logic             tmo_hit_c;
  logic             filt_done_c;
  logic             in_wait_c;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  assign rst_done_c  = (rst_cnt == RST_W'(RST_CYCLES - 1));
  assign tmo_hit_c   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign filt_done_c = locked_s && (filt_cnt == FLT_W'(LOCK_FILT - 1));
  assign in_wait_c   = (st == WAIT_LOCK) || (st == FILTER);
  assign tmo_dst_c   = (retry == RTY_W'(MAX_RETRY)) ? FAULT : RESET;

  // Next-state decode; disable overrides everything, READY completion beats timeout
  always_comb begin
    nxt_c = st;
    if (st != IDLE && !enable) begin
      nxt_c = IDLE;
    end else begin
      case (st)
        IDLE:      if (enable) nxt_c = RESET;
        RESET:     if (rst_done_c) nxt_c = WAIT_LOCK;
        WAIT_LOCK: begin
          if (tmo_hit_c)     nxt_c = tmo_dst_c;
          else if (locked_s) nxt_c = FILTER;
        end
        FILTER: begin
          if (filt_done_c)    nxt_c = READY;
          else if (tmo_hit_c) nxt_c = tmo_dst_c;
          else if (!locked_s) nxt_c = WAIT_LOCK;
        end
        READY:     if (!locked_s) nxt_c = RESET;
        FAULT:     if (clr_fault) nxt_c = IDLE;
        default:   nxt_c = IDLE;
      endcase
    end
  end

  // State, counters and Moore outputs decoded from the next state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      pll_rst   <= 1'b1;
      clk_ready <= 1'b0;
      fault     <= 1'b0;
      rst_cnt   <= '0;
      filt_cnt  <= '0;
      tmo_cnt   <= '0;
      retry     <= '0;
    end else begin
      st        <= nxt_c;
      pll_rst   <= (nxt_c == IDLE) || (nxt_c == RESET) || (nxt_c == FAULT);
      clk_ready <= (nxt_c == READY);
      fault     <= (nxt_c == FAULT);

      rst_cnt <= (st == RESET && nxt_c == RESET) ? rst_cnt + RST_W'(1) : '0;

      // Timeout spans the whole attempt, so a FILTER dropout does not restart it
      if (st == RESET && nxt_c == WAIT_LOCK)
        tmo_cnt <= '0;
      else if (in_wait_c && !tmo_hit_c)
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (st == WAIT_LOCK && nxt_c == FILTER)
        filt_cnt <= FLT_W'(1);
      else if (st == FILTER && nxt_c == FILTER)
        filt_cnt <= filt_cnt + FLT_W'(1);

      if (in_wait_c && nxt_c == RESET)
        retry <= retry + RTY_W'(1);
      else if (nxt_c == IDLE || nxt_c == READY || st == READY)
        retry <= '0;
    end
  end

  assign state = st;

`ifdef PLL_LOCK_CTRL_STAT_EN
  logic lose_lock_c;
  assign lose_lock_c = (st == READY) && (nxt_c == RESET);

  // Saturating loss-of-lock counter
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      relock_cnt <= '0;
    else if (lose_lock_c && relock_cnt != {CNT_W{1'b1}})
      relock_cnt <= relock_cnt + CNT_W'(1);
  end
`else
  assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: lock, glitch, timeout/fault, loss of lock, abort paths.
module tb_pll_lock_ctrl;

  localparam int unsigned RST_CYCLES     = 4;
  localparam int unsigned LOCK_FILT      = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned MAX_RETRY      = 2;
  localparam int unsigned CNT_W          = 8;

`ifdef PLL_LOCK_CTRL_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic             refclk;
  logic             rst_n;
  logic             enable;
  logic             clr_fault;
  logic             pll_locked;
  logic             pll_rst;
  logic             clk_ready;
  logic             fault;
  logic [CNT_W-1:0] relock_cnt;
  logic [2:0]       state;

  int total = 0;
  int bad   = 0;
  int nloss = 0;

  pll_lock_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_FILT     (LOCK_FILT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clr_fault (clr_fault),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .clk_ready (clk_ready),
    .fault     (fault),
    .relock_cnt(relock_cnt),
    .state     (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_relock(input int n);
    if (!STAT) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  // Drop lock while READY, check the reaction, then relock
  task automatic lose_lock(input bit full);
    int n;
    pll_locked = 1'b0;
    tick();
    tick();
    if (full) check("ready_hold_k1", 32'(clk_ready), 32'd1);
    tick();
    nloss++;
    check("relock_cnt", 32'(relock_cnt), 32'(exp_relock(nloss)));
    if (full) begin
      check("loss_clk_ready", 32'(clk_ready), 32'd0);
      check("loss_pll_rst", 32'(pll_rst), 32'd1);
      check("loss_state", 32'(state), 32'd1);
    end
    n = 1;
    tick();
    while (state === 3'd1 && n < 20) begin
      n++;
      tick();
    end
    if (full) begin
      check("loss_rst_width", 32'(n), 32'd4);
      check("loss_rst_fall", 32'(pll_rst), 32'd0);
    end
    pll_locked = 1'b1;
    wait_state("relock_ready", 3'd4, 20);
  endtask

  logic [2:0] gexp [11] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};

  initial begin
    int n;
    int t;
    int entries;
    logic [2:0] prevst;
    int ent_t [3];
    int width [3];

    rst_n      = 1'b0;
    enable     = 1'b0;
    clr_fault  = 1'b0;
    pll_locked = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_clk_ready", 32'(clk_ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_relock", 32'(relock_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_hold_state", 32'(state), 32'd0);
    check("idle_hold_rst", 32'(pll_rst), 32'd1);

    // Normal lock
    enable = 1'b1;
    tick();
    check("rst_enter", 32'(state), 32'd1);
    n = 1;
    tick();
    while (state === 3'd1 && n < 20) begin
      n++;
      tick();
    end
    check("rst_width", 32'(n), 32'd4);
    check("wait_lock_state", 32'(state), 32'd2);
    check("wait_lock_rst", 32'(pll_rst), 32'd0);
    repeat (9) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check("filter_not_yet", 32'(state), 32'd2);
    tick();
    check("filter_k2", 32'(state), 32'd3);
    tick();
    tick();
    check("ready_early", 32'(clk_ready), 32'd0);
    tick();
    check("ready_k5", 32'(clk_ready), 32'd1);
    check("ready_state", 32'(state), 32'd4);
    check("ready_fault", 32'(fault), 32'd0);
    check("ready_pll_rst", 32'(pll_rst), 32'd0);

    // Loss of lock, then saturation of the statistics counter
    lose_lock(1'b1);
    for (int i = 0; i < 259; i++) lose_lock(1'b0);
    check("relock_sat", 32'(relock_cnt), 32'(exp_relock(260)));
    check("relock_sat_ready", 32'(clk_ready), 32'd1);

    // Abort from READY and from mid-WAIT_LOCK
    enable = 1'b0;
    tick();
    check("dis_ready_state", 32'(state), 32'd0);
    check("dis_ready_rst", 32'(pll_rst), 32'd1);
    pll_locked = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    wait_state("abort_reach_wl", 3'd2, 10);
    repeat (3) tick();
    check("abort_in_wl", 32'(state), 32'd2);
    enable = 1'b0;
    tick();
    check("abort_state", 32'(state), 32'd0);
    check("abort_pll_rst", 32'(pll_rst), 32'd1);
    check("abort_relock_kept", 32'(relock_cnt), 32'(exp_relock(260)));

    // Lock glitch: high 2, low 3, then held high
    enable = 1'b1;
    wait_state("glitch_reach_wl", 3'd2, 10);
    pll_locked = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      check("glitch_state", 32'(state), 32'(gexp[i]));
      check("glitch_ready", 32'(clk_ready), (i == 10) ? 32'd1 : 32'd0);
      if (i == 1) pll_locked = 1'b0;
      if (i == 4) pll_locked = 1'b1;
    end

    // Never locks: three attempts then FAULT
    enable     = 1'b0;
    pll_locked = 1'b0;
    repeat (4) tick();
    check("nl_idle", 32'(state), 32'd0);
    enable  = 1'b1;
    t       = 0;
    entries = 0;
    prevst  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      ent_t[i] = 0;
      width[i] = 0;
    end
    while (state !== 3'd5 && t < 400) begin
      tick();
      t++;
      if (state === 3'd1 && prevst !== 3'd1) begin
        if (entries < 3) ent_t[entries] = t;
        entries++;
      end
      if (entries >= 1 && entries <= 3 && state !== 3'd5 && pll_rst === 1'b1)
        width[entries-1]++;
      prevst = state;
    end
    check("nl_attempts", 32'(entries), 32'd3);
    for (int i = 0; i < 3; i++) check("nl_pulse_width", 32'(width[i]), 32'd4);
    check("nl_spacing_1", 32'(ent_t[1] - ent_t[0]), 32'd68);
    check("nl_spacing_2", 32'(ent_t[2] - ent_t[1]), 32'd68);
    check("nl_fault_time", 32'(t), 32'd205);
    check("nl_fault_state", 32'(state), 32'd5);
    check("nl_fault", 32'(fault), 32'd1);
    check("nl_fault_rst", 32'(pll_rst), 32'd1);
    check("nl_fault_ready", 32'(clk_ready), 32'd0);
    repeat (3) tick();
    check("fault_hold", 32'(fault), 32'd1);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_pll_rst", 32'(pll_rst), 32'd1);

    // Asynchronous reset mid-FILTER
    pll_locked = 1'b1;
    wait_state("reach_filter", 3'd3, 20);
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_pll_rst", 32'(pll_rst), 32'd1);
    check("arst_clk_ready", 32'(clk_ready), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_relock", 32'(relock_cnt), 32'd0);
    #20;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
